// File: rtl/ufm_arbiter.sv
// Three-requester round-robin arbiter in front of a single UFM_WB engine.
// Optional grant timeout with requester masking is enabled by defining UFM_ARB_TIMEOUT_EN.
module ufm_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic [2:0]  REQ,
  input  logic [8:0]  REQ_CMD,
  input  logic [2:0]  REQ_GO,
  input  logic [2:0]  REQ_MEM_CE,
  input  logic [2:0]  REQ_MEM_WE,
  input  logic [11:0] REQ_MEM_ADDR,
  input  logic [23:0] REQ_MEM_WR_DATA,
  output logic [2:0]  GNT,
  output logic [2:0]  REQ_BUSY,
  output logic [2:0]  REQ_ERR,
  output logic [2:0]  UFM_CMD,
  output logic        UFM_GO,
  output logic        UFM_MEM_CE,
  output logic        UFM_MEM_WE,
  output logic [3:0]  UFM_MEM_ADDR,
  output logic [7:0]  UFM_MEM_WR_DATA,
  input  logic        UFM_BUSY,
  input  logic        UFM_ERR,
  output logic        TIMEOUT_ERR
);

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_GRANT   = 2'd1;
  localparam logic [1:0] ARB_RELEASE = 2'd2;

  logic [1:0] state;
  logic [2:0] gnt_q;
  logic [1:0] last_q;
  logic [2:0] eligible;
  logic [1:0] cand0, cand1, cand2;
  logic [1:0] pick_idx;
  logic [2:0] pick;
  logic       grant_now;
  logic       held;
  logic       tmo_hit;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Search order starts one past the last winner so every requester gets a turn.
  assign cand0 = inc3(last_q);
  assign cand1 = inc3(cand0);
  assign cand2 = inc3(cand1);

  always_comb begin
    if (eligible[cand0])      pick_idx = cand0;
    else if (eligible[cand1]) pick_idx = cand1;
    else                      pick_idx = cand2;
    pick = 3'b001 << pick_idx;
  end

  assign grant_now = (state == ARB_IDLE) && (|eligible) && !UFM_BUSY;
  assign held      = |(REQ & gnt_q);

`ifdef UFM_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic [2:0]  mask_q;
  logic        tmo_err_q;

  assign eligible    = REQ & ~mask_q;
  assign tmo_hit     = (state == ARB_GRANT) && held && (tmo_cnt == TIMEOUT - 16'd1);
  assign TIMEOUT_ERR = tmo_err_q;

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      tmo_cnt   <= '0;
      mask_q    <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_hit;
      // A timed-out requester stays masked until it is seen to drop its request.
      mask_q    <= (mask_q & REQ) | (tmo_hit ? gnt_q : 3'b000);
      if (grant_now)                tmo_cnt <= '0;
      else if (state == ARB_GRANT)  tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  logic unused_timeout;

  assign eligible       = REQ;
  assign tmo_hit        = 1'b0;
  assign TIMEOUT_ERR    = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state  <= ARB_IDLE;
      gnt_q  <= '0;
      last_q <= 2'd2;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_now) begin
            gnt_q  <= pick;
            last_q <= pick_idx;
            state  <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!held || tmo_hit) begin
            gnt_q <= '0;
            state <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          if (!UFM_BUSY) state <= ARB_IDLE;
        end
        default: begin
          gnt_q <= '0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // NOTE: every output gets its idle value first so this block can never infer a latch.
  always_comb begin
    UFM_CMD         = 3'b100;
    UFM_GO          = 1'b0;
    UFM_MEM_CE      = 1'b0;
    UFM_MEM_WE      = 1'b0;
    UFM_MEM_ADDR    = '0;
    UFM_MEM_WR_DATA = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_q[i]) begin
        UFM_CMD         = REQ_CMD[3*i +: 3];
        UFM_GO          = REQ_GO[i];
        UFM_MEM_CE      = REQ_MEM_CE[i];
        UFM_MEM_WE      = REQ_MEM_WE[i];
        UFM_MEM_ADDR    = REQ_MEM_ADDR[4*i +: 4];
        UFM_MEM_WR_DATA = REQ_MEM_WR_DATA[8*i +: 8];
      end
    end
  end

  assign GNT      = gnt_q;
  assign REQ_BUSY = ~gnt_q | {3{UFM_BUSY}};
  assign REQ_ERR  = gnt_q & {3{UFM_ERR}};

endmodule

// File: tb/tb_ufm_arbiter.sv
// Directed self-checking bench for ufm_arbiter (TIMEOUT=8); expectations follow UFM_ARB_TIMEOUT_EN.
module tb_ufm_arbiter;

  logic        SYSCLK = 1'b0;
  logic        RESET;
  logic [2:0]  REQ;
  logic [8:0]  REQ_CMD;
  logic [2:0]  REQ_GO;
  logic [2:0]  REQ_MEM_CE;
  logic [2:0]  REQ_MEM_WE;
  logic [11:0] REQ_MEM_ADDR;
  logic [23:0] REQ_MEM_WR_DATA;
  logic [2:0]  GNT;
  logic [2:0]  REQ_BUSY;
  logic [2:0]  REQ_ERR;
  logic [2:0]  UFM_CMD;
  logic        UFM_GO;
  logic        UFM_MEM_CE;
  logic        UFM_MEM_WE;
  logic [3:0]  UFM_MEM_ADDR;
  logic [7:0]  UFM_MEM_WR_DATA;
  logic        UFM_BUSY;
  logic        UFM_ERR;
  logic        TIMEOUT_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  ufm_arbiter #(.TIMEOUT(16'd8)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .REQ(REQ), .REQ_CMD(REQ_CMD), .REQ_GO(REQ_GO),
    .REQ_MEM_CE(REQ_MEM_CE), .REQ_MEM_WE(REQ_MEM_WE), .REQ_MEM_ADDR(REQ_MEM_ADDR),
    .REQ_MEM_WR_DATA(REQ_MEM_WR_DATA), .GNT(GNT), .REQ_BUSY(REQ_BUSY), .REQ_ERR(REQ_ERR),
    .UFM_CMD(UFM_CMD), .UFM_GO(UFM_GO), .UFM_MEM_CE(UFM_MEM_CE), .UFM_MEM_WE(UFM_MEM_WE),
    .UFM_MEM_ADDR(UFM_MEM_ADDR), .UFM_MEM_WR_DATA(UFM_MEM_WR_DATA), .UFM_BUSY(UFM_BUSY),
    .UFM_ERR(UFM_ERR), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  initial begin
    int order [4] = '{0, 1, 2, 0};
    logic [2:0] exp_g;

    RESET = 1'b1; REQ = '0; UFM_BUSY = 1'b0; UFM_ERR = 1'b0;
    REQ_CMD         = {3'b001, 3'b011, 3'b010};
    REQ_GO          = 3'b101;
    REQ_MEM_CE      = 3'b011;
    REQ_MEM_WE      = 3'b110;
    REQ_MEM_ADDR    = {4'hC, 4'h7, 4'h3};
    REQ_MEM_WR_DATA = {8'hF0, 8'h3C, 8'hA5};
    #1;
    check("rst_gnt", GNT, 3'b000);
    check("rst_cmd", UFM_CMD, 3'b100);
    check("rst_busy", REQ_BUSY, 3'b111);
    check("rst_err", REQ_ERR, 3'b000);
    check("rst_tmo", TIMEOUT_ERR, 1'b0);
    tick(); tick();
    RESET = 1'b0;

    // Single request from requester 0
    REQ = 3'b001;
    tick();
    check("g0_gnt", GNT, 3'b001);
    check("g0_cmd", UFM_CMD, 3'b010);
    check("g0_go", UFM_GO, 1'b1);
    check("g0_ce", UFM_MEM_CE, 1'b1);
    check("g0_we", UFM_MEM_WE, 1'b0);
    check("g0_addr", UFM_MEM_ADDR, 4'h3);
    check("g0_data", UFM_MEM_WR_DATA, 8'hA5);
    check("g0_busy", REQ_BUSY, 3'b110);
    UFM_BUSY = 1'b1; UFM_ERR = 1'b1; #1;
    check("g0_busy_fwd", REQ_BUSY, 3'b111);
    check("g0_err_fwd", REQ_ERR, 3'b001);
    UFM_BUSY = 1'b0; UFM_ERR = 1'b0;
    REQ = 3'b000;
    tick();
    check("g0_rel_gnt", GNT, 3'b000);
    check("g0_rel_cmd", UFM_CMD, 3'b100);
    check("g0_rel_data", UFM_MEM_WR_DATA, 8'h00);
    tick();

    // Round-robin with all three requesting, each releasing after 4 grant cycles
    RESET = 1'b1; #2; RESET = 1'b0;
    REQ = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp_g = 3'b001 << order[k];
      for (int c = 0; c < 4; c++) begin
        tick();
        check("rr_gnt", GNT, exp_g);
      end
      REQ[order[k]] = 1'b0;
      tick();
      check("rr_release", GNT, 3'b000);
      REQ[order[k]] = 1'b1;
      tick();
      check("rr_idle", GNT, 3'b000);
    end
    REQ = 3'b000;
    tick();

    // Requester 1 releases while engine busy; pending requester 2 waits
    REQ = 3'b010;
    tick();
    check("b1_gnt", GNT, 3'b010);
    check("b1_cmd", UFM_CMD, 3'b011);
    check("b1_go", UFM_GO, 1'b0);
    check("b1_we", UFM_MEM_WE, 1'b1);
    check("b1_data", UFM_MEM_WR_DATA, 8'h3C);
    REQ = 3'b110; UFM_BUSY = 1'b1; #1;
    check("b1_busy", REQ_BUSY, 3'b111);
    tick();
    check("b1_hold", GNT, 3'b010);
    REQ = 3'b100;
    tick();
    check("b1_release", GNT, 3'b000);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("b1_rel_wait", GNT, 3'b000);
    end
    UFM_BUSY = 1'b0;
    tick();
    check("b1_to_idle", GNT, 3'b000);
    tick();
    check("b2_gnt", GNT, 3'b100);
    check("b2_cmd", UFM_CMD, 3'b001);
    check("b2_ce", UFM_MEM_CE, 1'b0);
    check("b2_addr", UFM_MEM_ADDR, 4'hC);
    check("b2_data", UFM_MEM_WR_DATA, 8'hF0);
    check("b2_busy", REQ_BUSY, 3'b011);

    // Asynchronous reset between edges while granted
    #3; RESET = 1'b1; #1;
    check("arst_gnt", GNT, 3'b000);
    check("arst_cmd", UFM_CMD, 3'b100);
    check("arst_data", UFM_MEM_WR_DATA, 8'h00);
    check("arst_busy", REQ_BUSY, 3'b111);
    REQ = 3'b000; #2; RESET = 1'b0;
    tick();
    check("arst_idle", GNT, 3'b000);

    // Request drops in the same cycle the grant rises
    REQ = 3'b001;
    tick();
    check("short_gnt", GNT, 3'b001);
    REQ = 3'b000;
    tick();
    check("short_rel", GNT, 3'b000);
    tick();

    // No grant while the engine reports busy in idle
    REQ = 3'b001; UFM_BUSY = 1'b1;
    tick();
    check("idle_busy", GNT, 3'b000);
    UFM_BUSY = 1'b0;
    tick();
    check("idle_free", GNT, 3'b001);
    REQ = 3'b000;
    tick(); tick();

    // Requester 0 holds its request for 20 cycles
    RESET = 1'b1; #2; RESET = 1'b0;
    REQ = 3'b001;
    for (int t = 1; t <= 20; t++) begin
      tick();
`ifdef UFM_ARB_TIMEOUT_EN
      check("tmo_gnt", GNT, (t <= 8) ? 3'b001 : 3'b000);
      check("tmo_err", TIMEOUT_ERR, (t == 9) ? 1'b1 : 1'b0);
`else
      check("hold_gnt", GNT, 3'b001);
      check("hold_err", TIMEOUT_ERR, 1'b0);
`endif
    end
    REQ = 3'b000;
    tick();
    check("tmo_drop", GNT, 3'b000);
    REQ = 3'b001;
`ifndef UFM_ARB_TIMEOUT_EN
    tick();
    check("hold_idle", GNT, 3'b000);
`endif
    tick();
    check("tmo_regrant", GNT, 3'b001);
    check("tmo_err_end", TIMEOUT_ERR, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ufm_arbiter.md
UFM_ARBITER -- requirements
Module: ufm_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16'd1024, giving the maximum number of grant cycles before a forced release.
REQ-002 The block SHALL have port SYSCLK, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port REQ, input, 3, level request per requester; index 0, 1 and 2 select requesters.
REQ-005 The block SHALL have port REQ_CMD, input, 9, UFM command per requester, bits [3i+2:3i].
REQ-006 The block SHALL have port REQ_GO, input, 3, GO strobe per requester.
REQ-007 The block SHALL have ports REQ_MEM_CE (3), REQ_MEM_WE (3), REQ_MEM_ADDR (12, 4 bits each) and REQ_MEM_WR_DATA (24, 8 bits each), all inputs, carrying per-requester buffer-port signals.
REQ-008 The block SHALL have port GNT, output, 3, one-hot-or-zero grant.
REQ-009 The block SHALL have port REQ_BUSY, output, 3, per-requester BUSY view.
REQ-010 The block SHALL have port REQ_ERR, output, 3, per-requester ERR view.
REQ-011 The block SHALL have ports UFM_CMD (3), UFM_GO (1), UFM_MEM_CE (1), UFM_MEM_WE (1), UFM_MEM_ADDR (4) and UFM_MEM_WR_DATA (8), all outputs to the UFM_WB engine.
REQ-012 The block SHALL have ports UFM_BUSY and UFM_ERR, inputs, 1 each, from the UFM_WB engine.
REQ-013 The block SHALL have port TIMEOUT_ERR, output, 1, a one-cycle pulse on forced release.

Function
REQ-014 The FSM SHALL have three states: ARB_IDLE, ARB_GRANT and ARB_RELEASE.
REQ-015 In ARB_IDLE, when any eligible REQ bit is set and UFM_BUSY=0, the block SHALL register a one-hot GNT and enter ARB_GRANT on the same edge.
REQ-016 Arbitration SHALL be round-robin, searching from (last granted + 1) mod 3; after reset, last granted = 2, so requester 0 has the highest priority.
REQ-017 While GNT[i]=1, UFM_CMD, UFM_GO, UFM_MEM_CE, UFM_MEM_WE, UFM_MEM_ADDR and UFM_MEM_WR_DATA SHALL combinationally equal requester i's inputs in the same cycle.
REQ-018 When no grant is active, UFM_CMD SHALL be 3'b100, and UFM_GO, UFM_MEM_CE, UFM_MEM_WE, UFM_MEM_ADDR and UFM_MEM_WR_DATA SHALL be 0.
REQ-019 REQ_BUSY[i] SHALL equal UFM_BUSY when GNT[i]=1, and 1 otherwise.
REQ-020 REQ_ERR[i] SHALL equal UFM_ERR when GNT[i]=1, and 0 otherwise.
REQ-021 In ARB_GRANT, REQ[i] low for the granted i SHALL clear GNT and enter ARB_RELEASE on that edge.
REQ-022 In ARB_RELEASE, outputs SHALL be at the idle values of REQ-018, and the block SHALL return to ARB_IDLE on the first edge with UFM_BUSY=0; no new grant SHALL be issued in the same cycle.
REQ-023 Requests from other requesters arriving during ARB_GRANT or ARB_RELEASE SHALL wait; they SHALL NOT be lost while held.
REQ-024 If REQ drops in the same cycle GNT rises, the grant SHALL still be issued and SHALL release on the next edge.
REQ-025 Minimum re-grant latency SHALL be 3 cycles: IDLE to GRANT, GRANT to RELEASE, then RELEASE to IDLE.

Reset
REQ-026 On RESET, the block SHALL asynchronously set state=ARB_IDLE, GNT=0, last-granted=2, TIMEOUT_ERR=0, the timeout counter=0, and the eligibility mask to all-eligible.
REQ-027 On RESET, the UFM outputs SHALL immediately take the idle values of REQ-018, including when reset is asserted mid-grant.

Configuration
REQ-028 With macro UFM_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL run in ARB_GRANT.
REQ-029 With UFM_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT-1 while REQ is still held, the block SHALL clear GNT, enter ARB_RELEASE, pulse TIMEOUT_ERR for one cycle, and mask that requester.
REQ-030 A masked requester SHALL NOT be eligible for grant until its REQ has been sampled low.
REQ-031 With UFM_ARB_TIMEOUT_EN defined, the counter SHALL clear on entering ARB_GRANT.
REQ-032 Without UFM_ARB_TIMEOUT_EN, no counter or mask SHALL exist, TIMEOUT_ERR SHALL be tied to 0, and a grant SHALL be held indefinitely.

Verification
REQ-033 REQ=3'b001 with UFM_BUSY=0 -> GNT=3'b001 after 1 edge; UFM_CMD follows REQ_CMD[2:0]=3'b010; REQ_BUSY=3'b110.
REQ-034 REQ=3'b111 held, each grant releasing after 4 cycles -> grant order 0, 1, 2, 0; never two GNT bits set.
REQ-035 Requester 1 releases while UFM_BUSY=1 for 5 more cycles -> state stays ARB_RELEASE for 5 cycles; pending REQ[2] is granted only afterwards.
REQ-036 RESET asserted mid-grant, between edges -> GNT=0 and UFM_CMD=3'b100 immediately, without waiting for a clock edge.
REQ-037 With UFM_ARB_TIMEOUT_EN and TIMEOUT=8, REQ[0] held 20 cycles -> GNT[0] drops after 8 grant cycles and TIMEOUT_ERR pulses once; requester 0 is not re-granted until REQ[0] goes low then high.
REQ-038 Without UFM_ARB_TIMEOUT_EN, the same stimulus as REQ-037 -> GNT[0] is held for all 20 cycles and TIMEOUT_ERR stays 0.
